move_sequencer: RTL and testbench

//   Owns the 4x4 game grid and sequences every change to it: debug cell writes, one-line-per-cycle

---
 rtl/move_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Owns the 4x4 tile grid and sequences debug writes, line-at-a-time slide/merge passes,
// the changed-grid check, new-tile spawn and the win/game-over flags.
module move_sequencer #(
    parameter int P_FOUR  = 1,
    parameter int WIN_EXP = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_req,
    input  logic [3:0]  move_dir,
    input  logic        dbg_wr_valid,
    input  logic [3:0]  dbg_wr_addr,
    input  logic [3:0]  dbg_wr_data,
    input  logic [7:0]  rnd_in,
    output logic [63:0] grid_out,
    output logic        busy,
    output logic        moved,
    output logic        won,
    output logic        game_over
);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_SPAWN, S_DONE} state_t;

    localparam logic [3:0] WIN_V  = 4'(WIN_EXP);
    localparam logic [3:0] FOUR_V = 4'(P_FOUR);

    state_t      state_q, state_d;
    logic [63:0] grid_q, grid_d;
    logic [63:0] snap_q, snap_d;
    logic [3:0]  dir_q, dir_d;
    logic [1:0]  line_q, line_d;
    logic        pend_q, pend_d;
    logic [3:0]  pendDir_q, pendDir_d;
    logic [3:0]  spawnIdx_q, spawnIdx_d;
    logic [3:0]  spawnVal_q, spawnVal_d;
    logic        spawnFirst_q, spawnFirst_d;
    logic        moved_q, moved_d;
    logic        won_q, won_d;
    logic        over_q, over_d;

    // Grid index of position pos (0 = destination end) along the selected line for direction dir.
    function automatic logic [3:0] cellIdx(input logic [3:0] dir, input logic [1:0] line,
                                           input logic [1:0] pos);
        logic [3:0] idx;
        if (dir[0])      idx = {pos, line};
        else if (dir[1]) idx = {~pos, line};
        else if (dir[3]) idx = {line, ~pos};
        else if (dir[2]) idx = {line, pos};
        else             idx = {line, pos};
        return idx;
    endfunction

    function automatic logic [15:0] slideLine(input logic [15:0] lineIn);
        logic [3:0]  c [5];
        logic [3:0]  o [4];
        logic [2:0]  n;
        logic [1:0]  m;
        logic        skip;
        logic [15:0] res;
        for (int i = 0; i < 5; i++) c[i] = 4'd0;
        for (int i = 0; i < 4; i++) o[i] = 4'd0;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (lineIn[i*4 +: 4] != 4'd0) begin
                c[n] = lineIn[i*4 +: 4];
                n = n + 3'd1;
            end
        end
        // A merged pair consumes both inputs, so the merged result cannot merge again.
        m = 2'd0;
        skip = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[k] != 4'd0 && c[k] == c[k+1]) begin
                o[m] = (c[k] == 4'hF) ? 4'hF : c[k] + 4'd1;
                m = m + 2'd1;
                skip = 1'b1;
            end else begin
                o[m] = c[k];
                m = m + 2'd1;
            end
        end
        for (int i = 0; i < 4; i++) res[i*4 +: 4] = o[i];
        return res;
    endfunction

    function automatic logic anyWin(input logic [63:0] g);
        logic w;
        w = 1'b0;
        for (int i = 0; i < 16; i++) if (g[i*4 +: 4] >= WIN_V) w = 1'b1;
        return w;
    endfunction

    function automatic logic isOver(input logic [63:0] g);
        logic canMove;
        canMove = 1'b0;
        for (int i = 0; i < 16; i++) if (g[i*4 +: 4] == 4'd0) canMove = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (g[(r*4+c)*4 +: 4] == g[(r*4+c+1)*4 +: 4]) canMove = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (g[(r*4+c)*4 +: 4] == g[((r+1)*4+c)*4 +: 4]) canMove = 1'b1;
        return !canMove;
    endfunction

    logic        reqValid;
    logic [15:0] lineIn;
    logic [15:0] slid;
    logic [3:0]  curIdx;
    logic [3:0]  curVal;

    assign reqValid = move_req && (move_dir != 4'd0) && ((move_dir & (move_dir - 4'd1)) == 4'd0);

    // Next-state logic for the move sequencer: debug writes, slide passes, check, spawn and flags.
    always_comb begin
        state_d      = state_q;
        grid_d       = grid_q;
        snap_d       = snap_q;
        dir_d        = dir_q;
        line_d       = line_q;
        pend_d       = pend_q;
        pendDir_d    = pendDir_q;
        spawnIdx_d   = spawnIdx_q;
        spawnVal_d   = spawnVal_q;
        spawnFirst_d = spawnFirst_q;
        moved_d      = 1'b0;
        won_d        = won_q;
        over_d       = over_q;
        lineIn       = 16'd0;
        slid         = 16'd0;
        curIdx       = 4'd0;
        curVal       = 4'd0;

        if (state_q != S_IDLE && reqValid && !pend_q) begin
            pend_d    = 1'b1;
            pendDir_d = move_dir;
        end

        case (state_q)
            S_IDLE: begin
                if (dbg_wr_valid) grid_d[{dbg_wr_addr, 2'b00} +: 4] = dbg_wr_data;
                if (reqValid) begin
                    snap_d  = grid_d;
                    dir_d   = move_dir;
                    line_d  = 2'd0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                for (int p = 0; p < 4; p++)
                    lineIn[p*4 +: 4] = grid_q[{cellIdx(dir_q, line_q, 2'(p)), 2'b00} +: 4];
                slid = slideLine(lineIn);
                for (int p = 0; p < 4; p++)
                    grid_d[{cellIdx(dir_q, line_q, 2'(p)), 2'b00} +: 4] = slid[p*4 +: 4];
                line_d = line_q + 2'd1;
                if (line_q == 2'd3) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (grid_q != snap_q) begin
                    moved_d      = 1'b1;
                    spawnFirst_d = 1'b1;
                    state_d      = S_SPAWN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SPAWN: begin
                // First scan cycle takes position and value straight from the random bits.
                curIdx = spawnFirst_q ? rnd_in[3:0] : spawnIdx_q;
                curVal = spawnFirst_q ? ((rnd_in[7:4] < FOUR_V) ? 4'd2 : 4'd1) : spawnVal_q;
                spawnFirst_d = 1'b0;
                if (grid_q[{curIdx, 2'b00} +: 4] == 4'd0) begin
                    grid_d[{curIdx, 2'b00} +: 4] = curVal;
                    state_d = S_DONE;
                end else begin
                    spawnIdx_d = curIdx + 4'd1;
                    spawnVal_d = curVal;
                end
            end
            S_DONE: begin
                won_d  = anyWin(grid_q);
                over_d = isOver(grid_q);
                if (pend_q) begin
                    pend_d  = 1'b0;
                    snap_d  = grid_q;
                    dir_d   = pendDir_q;
                    line_d  = 2'd0;
                    state_d = S_SHIFT;
                end else if (reqValid) begin
                    pend_d  = 1'b0;
                    snap_d  = grid_q;
                    dir_d   = move_dir;
                    line_d  = 2'd0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset that also aborts any move in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grid_q       <= 64'd0;
            snap_q       <= 64'd0;
            dir_q        <= 4'd0;
            line_q       <= 2'd0;
            pend_q       <= 1'b0;
            pendDir_q    <= 4'd0;
            spawnIdx_q   <= 4'd0;
            spawnVal_q   <= 4'd0;
            spawnFirst_q <= 1'b0;
            moved_q      <= 1'b0;
            won_q        <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grid_q       <= grid_d;
            snap_q       <= snap_d;
            dir_q        <= dir_d;
            line_q       <= line_d;
            pend_q       <= pend_d;
            pendDir_q    <= pendDir_d;
            spawnIdx_q   <= spawnIdx_d;
            spawnVal_q   <= spawnVal_d;
            spawnFirst_q <= spawnFirst_d;
            moved_q      <= moved_d;
            won_q        <= won_d;
            over_q       <= over_d;
        end
    end

    assign grid_out  = grid_q;
    assign busy      = (state_q != S_IDLE);
    assign moved     = moved_q;
    assign won       = won_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: hand-computed grids, busy lengths and flag values.
module tb_move_sequencer;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_req = 1'b0;
    logic [3:0]  move_dir = 4'd0;
    logic        dbg_wr_valid = 1'b0;
    logic [3:0]  dbg_wr_addr = 4'd0;
    logic [3:0]  dbg_wr_data = 4'd0;
    logic [7:0]  rnd_in = 8'd0;
    logic [63:0] grid_out;
    logic        busy;
    logic        moved;
    logic        won;
    logic        game_over;

    int compareCount  = 0;
    int mismatchCount = 0;

    move_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .move_req     (move_req),
        .move_dir     (move_dir),
        .dbg_wr_valid (dbg_wr_valid),
        .dbg_wr_addr  (dbg_wr_addr),
        .dbg_wr_data  (dbg_wr_data),
        .rnd_in       (rnd_in),
        .grid_out     (grid_out),
        .busy         (busy),
        .moved        (moved),
        .won          (won),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic writeCell(input logic [3:0] addr, input logic [3:0] data);
        dbg_wr_valid = 1'b1;
        dbg_wr_addr  = addr;
        dbg_wr_data  = data;
        tick();
        dbg_wr_valid = 1'b0;
    endtask

    // Issues one move from IDLE and counts busy cycles and moved pulses until idle again.
    task automatic applyStimulus(input logic [3:0] dir, output int busyCycles, output int movedPulses);
        move_req = 1'b1;
        move_dir = dir;
        tick();
        move_req = 1'b0;
        move_dir = 4'd0;
        busyCycles  = 0;
        movedPulses = 0;
        while (busy && busyCycles < 200) begin
            busyCycles++;
            if (moved) movedPulses++;
            tick();
        end
    endtask

    initial begin
        int          nBusy;
        int          nMoved;
        logic [63:0] expGrid;

        $display("[TB] start");

        // Reset state
        doReset();
        checkOutput("reset grid", grid_out, 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset moved", 64'(moved), 64'd0);
        checkOutput("reset won", 64'(won), 64'd0);
        checkOutput("reset game_over", 64'(game_over), 64'd0);

        // Test 1: two 2s merge left, spawn a "2" at cell 2
        rnd_in = 8'h12;
        writeCell(4'd0, 4'd1);
        writeCell(4'd1, 4'd1);
        checkOutput("t1 dbg write", grid_out, 64'h0000_0000_0000_0011);
        applyStimulus(DIR_LEFT, nBusy, nMoved);
        checkOutput("t1 grid", grid_out, 64'h0000_0000_0000_0102);
        checkOutput("t1 busy cycles", 64'(nBusy), 64'd7);
        checkOutput("t1 moved pulses", 64'(nMoved), 64'd1);
        checkOutput("t1 won", 64'(won), 64'd0);
        checkOutput("t1 game_over", 64'(game_over), 64'd0);

        // Test 2: row0 [1,1,2,2] right -> [0,0,2,3], spawn at cell 0
        doReset();
        rnd_in = 8'h10;
        writeCell(4'd0, 4'd1);
        writeCell(4'd1, 4'd1);
        writeCell(4'd2, 4'd2);
        writeCell(4'd3, 4'd2);
        applyStimulus(DIR_RIGHT, nBusy, nMoved);
        checkOutput("t2 grid", grid_out, 64'h0000_0000_0000_3201);
        checkOutput("t2 busy cycles", 64'(nBusy), 64'd7);
        checkOutput("t2 moved pulses", 64'(nMoved), 64'd1);

        // Test 3: lone tile at cell 0 moved up does nothing
        doReset();
        rnd_in = 8'h15;
        writeCell(4'd0, 4'd1);
        applyStimulus(DIR_UP, nBusy, nMoved);
        checkOutput("t3 grid", grid_out, 64'h0000_0000_0000_0001);
        checkOutput("t3 busy cycles", 64'(nBusy), 64'd6);
        checkOutput("t3 moved pulses", 64'(nMoved), 64'd0);

        // Test 4: down queued, left dropped, debug write ignored while busy
        doReset();
        rnd_in = 8'h13;
        writeCell(4'd0, 4'd1);
        move_req = 1'b1;
        move_dir = DIR_RIGHT;
        tick();
        move_req = 1'b0;
        nBusy  = 0;
        nMoved = 0;
        while (busy && nBusy < 200) begin
            nBusy++;
            if (moved) nMoved++;
            move_req     = 1'b0;
            move_dir     = 4'd0;
            dbg_wr_valid = 1'b0;
            if (nBusy == 1) begin
                move_req = 1'b1;
                move_dir = DIR_DOWN;
            end else if (nBusy == 3) begin
                move_req = 1'b1;
                move_dir = DIR_LEFT;
            end else if (nBusy == 4) begin
                dbg_wr_valid = 1'b1;
                dbg_wr_addr  = 4'd5;
                dbg_wr_data  = 4'd7;
            end
            tick();
        end
        move_req     = 1'b0;
        dbg_wr_valid = 1'b0;
        checkOutput("t4 grid", grid_out, 64'h1001_0000_0000_1000);
        checkOutput("t4 busy cycles", 64'(nBusy), 64'd15);
        checkOutput("t4 moved pulses", 64'(nMoved), 64'd2);
        tick();
        checkOutput("t4 idle after", 64'(busy), 64'd0);

        // Slide rule rows and saturation at 15
        doReset();
        rnd_in = 8'h10;
        writeCell(4'd4, 4'd1);
        writeCell(4'd5, 4'd1);
        writeCell(4'd6, 4'd1);
        writeCell(4'd8, 4'd2);
        writeCell(4'd10, 4'd2);
        writeCell(4'd11, 4'd3);
        writeCell(4'd12, 4'd15);
        writeCell(4'd13, 4'd15);
        applyStimulus(DIR_LEFT, nBusy, nMoved);
        checkOutput("slide grid", grid_out, 64'h000F_0033_0012_0001);
        checkOutput("slide busy cycles", 64'(nBusy), 64'd7);
        checkOutput("slide won", 64'(won), 64'd1);

        // Test 5: checkerboard -> game over, then a win
        doReset();
        rnd_in  = 8'h10;
        expGrid = 64'd0;
        for (int n = 0; n < 16; n++) begin
            logic [3:0] v;
            v = ((((n >> 2) + (n & 3)) & 1) != 0) ? 4'd2 : 4'd1;
            expGrid[n*4 +: 4] = v;
            writeCell(4'(n), v);
        end
        checkOutput("t5 over before move", 64'(game_over), 64'd0);
        applyStimulus(DIR_UP, nBusy, nMoved);
        checkOutput("t5 board grid", grid_out, expGrid);
        checkOutput("t5 busy cycles", 64'(nBusy), 64'd6);
        checkOutput("t5 game_over", 64'(game_over), 64'd1);
        checkOutput("t5 won before", 64'(won), 64'd0);
        writeCell(4'd0, 4'd0);
        expGrid[3:0] = 4'd0;
        checkOutput("t5 dbg grid", grid_out, expGrid);
        checkOutput("t5 over held", 64'(game_over), 64'd1);

        doReset();
        rnd_in = 8'h10;
        writeCell(4'd0, 4'd11);
        checkOutput("t5 won not on dbg", 64'(won), 64'd0);
        applyStimulus(DIR_RIGHT, nBusy, nMoved);
        checkOutput("t5 win grid", grid_out, 64'h0000_0000_0000_B001);
        checkOutput("t5 won", 64'(won), 64'd1);
        checkOutput("t5 over cleared", 64'(game_over), 64'd0);

        // Test 6: reset mid-shift aborts the move and its queued follow-up
        doReset();
        rnd_in = 8'h10;
        writeCell(4'd1, 4'd1);
        move_req = 1'b1;
        move_dir = DIR_LEFT;
        tick();
        move_dir = DIR_DOWN;
        tick();
        move_req = 1'b0;
        move_dir = 4'd0;
        checkOutput("t6 busy in shift", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6 grid after rst", grid_out, 64'd0);
        checkOutput("t6 busy after rst", 64'(busy), 64'd0);
        tick();
        tick();
        tick();
        checkOutput("t6 pending cleared", 64'(busy), 64'd0);
        move_req = 1'b1;
        move_dir = 4'b0011;
        tick();
        move_req = 1'b0;
        move_dir = 4'd0;
        checkOutput("t6 bad dir ignored", 64'(busy), 64'd0);
        tick();
        checkOutput("t6 still idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
